// File: rtl/hazard_pkg.sv
// Shared constants and the mul/div timer state encoding for the hazard controller.
package hazard_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  localparam int         MD_LATENCY_DEF = 32;
  localparam int         STALL_CNT_W    = 16;
  localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/muldiv_timer.sv
// Occupancy timer for the multi-cycle multiply/divide unit.
// An op seen in EX loads the countdown; the unit reports busy until the
// countdown reaches zero, and that final busy cycle is flagged as done.
module muldiv_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic muldiv_i,
  output logic busy_o,
  output logic done_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and countdown registers; reset aborts any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a new op is only accepted from idle, since the stall logic
  // keeps a second op out of EX while the unit is occupied.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (muldiv_i) begin
          cnt_d   = CNT_W'(MD_LATENCY - 1);
          state_d = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags derive purely from the registered state.
  always_comb begin
    busy_o = (state_q == ST_MD_BUSY);
    done_o = busy_o && (cnt_q == '0);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard and stall sequencer: combines load-use and HI/LO hazards,
// lets a taken branch override any stall by flushing the front end, and
// counts stalled cycles with a saturating counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ID_EX_MemRead,
  input  logic [4:0]             ID_EX_RegRt,
  input  logic                   ID_EX_MulDiv,
  input  logic [4:0]             IF_ID_RegRs,
  input  logic [4:0]             IF_ID_RegRt,
  input  logic                   IF_ID_HiLoUse,
  input  logic                   EX_Branch_Taken,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   MD_Busy,
  output logic                   MD_Done,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  logic                   load_use;
  logic                   hilo_use;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  muldiv_timer #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_muldiv_timer (
    .clk      (clk),
    .rst      (rst),
    .muldiv_i (ID_EX_MulDiv),
    .busy_o   (MD_Busy),
    .done_o   (MD_Done)
  );

  // Hazard detection; register zero never creates a dependence.
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_RegRt != REG_ZERO) &&
               ((ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt));
    hilo_use = IF_ID_HiLoUse && (MD_Busy || ID_EX_MulDiv);
    stall    = (load_use || hilo_use) && !EX_Branch_Taken;
  end

  // Pipeline control in priority order: reset, taken branch, stall, run.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (rst) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (EX_Branch_Taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  // Stall counter next value: count frozen-PC cycles, hold at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller with a short mul/div latency.
module tb_hazard_controller;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        muldiv = 1'b0;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        hilo = 1'b0;
  logic        br = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, md_busy, md_done;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: busy cycles still remaining, and stalled-cycle tally.
  int rem = 0;
  int cnt = 0;

  hazard_controller #(.MD_LATENCY(LAT), .CNT_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_EX_MemRead   (mem_read),
    .ID_EX_RegRt     (ex_rt),
    .ID_EX_MulDiv    (muldiv),
    .IF_ID_RegRs     (id_rs),
    .IF_ID_RegRt     (id_rt),
    .IF_ID_HiLoUse   (hilo),
    .EX_Branch_Taken (br),
    .PC_Write        (pc_write),
    .IF_ID_Write     (ifid_write),
    .IF_ID_Flush     (ifid_flush),
    .ID_EX_Flush     (idex_flush),
    .MD_Busy         (md_busy),
    .MD_Done         (md_done),
    .Stall_Count     (stall_count)
  );

  // Clock block.
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model predicates taken straight from the hazard rules.
  function automatic bit m_busy();  return rem > 0;  endfunction
  function automatic bit m_done();  return rem == 1; endfunction
  function automatic bit m_stall();
    bit lu, hu;
    lu = mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    hu = hilo && (m_busy() || muldiv);
    return (lu || hu) && !br;
  endfunction
  function automatic bit m_pc();
    if (rst) return 0;
    if (br) return 1;
    return !m_stall();
  endfunction
  function automatic bit m_ifid_flush();
    return rst || br;
  endfunction
  function automatic bit m_idex_flush();
    return rst || br || m_stall();
  endfunction

  // Model update on each clock edge (or asynchronous reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0;
      cnt = 0;
    end else begin
      if (!m_pc()) cnt = (cnt < 65535) ? cnt + 1 : 65535;
      if (rem > 0) rem = rem - 1;
      else if (muldiv) rem = LAT;
    end
  end

  // Compare process: every negative edge, all outputs against the model.
  always @(negedge clk) begin
    check("pc_write",    int'(pc_write),    int'(m_pc()));
    check("if_id_write", int'(ifid_write),  int'(m_pc()));
    check("if_id_flush", int'(ifid_flush),  int'(m_ifid_flush()));
    check("id_ex_flush", int'(idex_flush),  int'(m_idex_flush()));
    check("md_busy",     int'(md_busy),     int'(m_busy()));
    check("md_done",     int'(md_done),     int'(m_done()));
    check("stall_count", int'(stall_count), cnt);
    if (!rst && muldiv) check("muldiv_while_busy", int'(m_busy()), 0);
  end

  // Driver: advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; ex_rt = 0; muldiv = 0; id_rs = 0; id_rt = 0; hilo = 0; br = 0;
  endtask

  initial begin
    bit done_seen;
    // Reset state.
    rst = 1;
    #1;
    check("rst_pc_write",  int'(pc_write),   0);
    check("rst_if_flush",  int'(ifid_flush), 1);
    check("rst_ex_flush",  int'(idex_flush), 1);
    repeat (2) tick();
    check("rst_busy",      int'(md_busy),     0);
    check("rst_done",      int'(md_done),     0);
    check("rst_count",     int'(stall_count), 0);
    rst = 0;
    repeat (3) tick();

    // Mul/div with HI/LO consumer held from the issue cycle.
    muldiv = 1; hilo = 1;
    for (int k = 0; k <= 5; k++) begin
      #1;
      check("md_pc_write", int'(pc_write), (k <= 4) ? 0 : 1);
      check("md_busy_lit", int'(md_busy),  (k >= 1 && k <= 4) ? 1 : 0);
      check("md_done_lit", int'(md_done),  (k == 4) ? 1 : 0);
      tick();
      muldiv = 0;
    end
    check("md_stall_count", int'(stall_count), 5);
    hilo = 0;
    tick();

    // Load-use: single-cycle stall.
    mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
    #1;
    check("lu_pc_write", int'(pc_write),   0);
    check("lu_ifid_wr",  int'(ifid_write), 0);
    check("lu_ex_flush", int'(idex_flush), 1);
    check("lu_if_flush", int'(ifid_flush), 0);
    tick();
    idle_inputs();
    #1;
    check("lu_count", int'(stall_count), 6);
    check("lu_after", int'(pc_write),    1);

    // Same pattern on register zero: no hazard.
    mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    check("r0_pc_write", int'(pc_write), 1);
    tick();
    // Match through rt rather than rs.
    mem_read = 1; ex_rt = 5'd17; id_rs = 5'd2; id_rt = 5'd17;
    #1;
    check("lu_rt_pc_write", int'(pc_write), 0);
    tick();
    idle_inputs();
    #1;
    check("lu_rt_count", int'(stall_count), 7);

    // Taken branch overrides a load-use stall.
    mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9; br = 1;
    #1;
    check("br_pc_write", int'(pc_write),   1);
    check("br_if_flush", int'(ifid_flush), 1);
    check("br_ex_flush", int'(idex_flush), 1);
    tick();
    idle_inputs();
    #1;
    check("br_count", int'(stall_count), 7);

    // Reset during the second busy cycle.
    muldiv = 1;
    tick();
    muldiv = 0;
    tick();
    check("mid_busy_before", int'(md_busy), 1);
    rst = 1;
    #1;
    check("mid_busy_async", int'(md_busy),    0);
    check("mid_pc_write",   int'(pc_write),   0);
    check("mid_if_flush",   int'(ifid_flush), 1);
    check("mid_ex_flush",   int'(idex_flush), 1);
    tick();
    rst = 0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (md_done) done_seen = 1;
    end
    check("mid_no_done", int'(done_seen),    0);
    check("mid_count",   int'(stall_count), 0);

    // Saturation: continuous load-use stall beyond the counter range.
    mem_read = 1; ex_rt = 5'd4; id_rs = 5'd4;
    repeat (65540) tick();
    check("sat_count", int'(stall_count), 16'hFFFF);
    repeat (20) tick();
    check("sat_hold", int'(stall_count), 16'hFFFF);
    idle_inputs();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
